bitstream_fetch_ctrl: RTL and testbench



---
 rtl/bfc_pkg.sv | 21 ++
 rtl/bfc_bit_buffer.sv | 68 ++++++
 rtl/bitstream_fetch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bitstream_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bfc_pkg.sv
// Shared definitions for the bitstream fetch controller.
//   bfc_state_e   : fetch FSM states (idle, waiting for a word, end of stream)
//   MAX_READ_BITS : widest single consumer read
//   NBITS_W       : width of the consumer bit-count field
//   fill_width()  : width of a counter able to hold 0..buf_w
package bfc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EOS  = 2'd2
    } bfc_state_e;

    localparam int MAX_READ_BITS = 9;
    localparam int NBITS_W       = 4;

    function automatic int fill_width(input int buf_w);
        return $clog2(buf_w + 1);
    endfunction

endpackage

// File: rtl/bfc_bit_buffer.sv
// MSB-first bit buffer with fill counter.
// The oldest stream bit always sits at data_o[BUF_W-1]; bits below the fill
// level are kept at zero so reads past the valid data come out zero-padded.
// In one cycle the consume (or clear) is applied first, then an appended word
// lands directly below the remaining valid bits.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   append_en_i  : append word_i this cycle
//   word_i       : word to append, MSB first
//   consume_n_i  : bits removed from the top this cycle (0..MAX_READ_BITS)
//   clear_i      : drop all buffered bits (underflow read)
//   data_o       : buffer contents
//   fill_o       : number of valid bits
module bfc_bit_buffer
    import bfc_pkg::*;
#(
    parameter int  WORD_W = 9,
    parameter int  BUF_W  = 32,
    localparam int FILL_W = fill_width(BUF_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               append_en_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic [NBITS_W-1:0] consume_n_i,
    input  logic               clear_i,
    output logic [BUF_W-1:0]   data_o,
    output logic [FILL_W-1:0]  fill_o
);

    logic [BUF_W-1:0]  data_q, data_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_s;
    logic [BUF_W-1:0]  word_ext;

    assign word_ext = {word_i, {(BUF_W - WORD_W){1'b0}}};

    always_comb begin
        shifted = data_q << consume_n_i;
        fill_s  = fill_q - FILL_W'(consume_n_i);
        if (clear_i) begin
            shifted = '0;
            fill_s  = '0;
        end
        data_d = shifted;
        fill_d = fill_s;
        if (append_en_i) begin
            // The refill threshold guarantees fill_s + WORD_W <= BUF_W here.
            data_d = shifted | (word_ext >> fill_s);
            fill_d = fill_s + FILL_W'(WORD_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            fill_q <= '0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign data_o = data_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/bitstream_fetch_ctrl.sv
// Bitstream fetch controller for the arithmetic decoder.
// Keeps an MSB-first bit buffer topped up from a word source (one request
// outstanding at most) and serves 0..9-bit reads to the decoder engine.
// End of stream comes from src_eos_i or from a source timeout.
// Optional build macro BFC_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   src_req_o         : single-cycle fetch pulse
//   src_data_i        : fetched word, MSB first
//   src_valid_i       : one-cycle strobe qualifying src_data_i
//   src_eos_i         : source has no more data (sampled while waiting)
//   cons_req_i        : read request, held until cons_ack_o
//   cons_nbits_i      : bits requested (values above 9 read 9)
//   cons_ack_o        : one-cycle acknowledge
//   cons_bits_o       : read bits, right-aligned, zero-extended
//   cons_underflow_o  : read was zero-padded past end of stream
//   eos_o             : sticky end-of-stream flag
//   fill_level_o      : valid bits in the buffer
//   stat_words_o      : (BFC_STATS_EN) accepted source words
//   stat_bits_o       : (BFC_STATS_EN) bits delivered, padding included
// Handshake: a read is evaluated on any cycle where cons_req_i is high and
// cons_ack_o was low the cycle before; cons_ack_o then pulses for one cycle.
module bitstream_fetch_ctrl
    import bfc_pkg::*;
#(
    parameter int  WORD_W      = 9,
    parameter int  BUF_W       = 32,
    parameter int  TIMEOUT_CYC = 64,
    localparam int FILL_W      = fill_width(BUF_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     src_req_o,
    input  logic [WORD_W-1:0]        src_data_i,
    input  logic                     src_valid_i,
    input  logic                     src_eos_i,
    input  logic                     cons_req_i,
    input  logic [NBITS_W-1:0]       cons_nbits_i,
    output logic                     cons_ack_o,
    output logic [MAX_READ_BITS-1:0] cons_bits_o,
    output logic                     cons_underflow_o,
    output logic                     eos_o,
    output logic [FILL_W-1:0]        fill_level_o
`ifdef BFC_STATS_EN
   ,output logic [31:0]              stat_words_o,
    output logic [31:0]              stat_bits_o
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    bfc_state_e               state_q;
    logic                     src_req_q;
    logic                     eos_q;
    logic [TMO_W-1:0]         tmo_q;
    logic                     cons_ack_q;
    logic [MAX_READ_BITS-1:0] cons_bits_q;
    logic                     cons_under_q;

    logic [BUF_W-1:0]         buf_data;
    logic [FILL_W-1:0]        fill;
    logic [NBITS_W-1:0]       n_eff;
    logic [MAX_READ_BITS-1:0] peek;
    logic                     eval;
    logic                     rd_ok;
    logic                     rd_under;
    logic                     rd_fire;
    logic                     append_en;

    assign n_eff = (cons_nbits_i > NBITS_W'(MAX_READ_BITS)) ? NBITS_W'(MAX_READ_BITS)
                                                             : cons_nbits_i;
    // Top n bits of the buffer, right-aligned; n = 0 yields zero.
    assign peek = buf_data[BUF_W-1 -: MAX_READ_BITS] >> (NBITS_W'(MAX_READ_BITS) - n_eff);

    assign eval      = cons_req_i && !cons_ack_q;
    assign rd_ok     = eval && (fill >= FILL_W'(n_eff));
    assign rd_under  = eval && (fill < FILL_W'(n_eff)) && eos_q;
    assign rd_fire   = rd_ok || rd_under;
    assign append_en = (state_q == S_WAIT) && src_valid_i;

    bfc_bit_buffer #(
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .append_en_i (append_en),
        .word_i      (src_data_i),
        .consume_n_i (rd_ok ? n_eff : '0),
        .clear_i     (rd_under),
        .data_o      (buf_data),
        .fill_o      (fill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_req_q    <= 1'b0;
            eos_q        <= 1'b0;
            tmo_q        <= '0;
            cons_ack_q   <= 1'b0;
            cons_bits_q  <= '0;
            cons_under_q <= 1'b0;
        end else begin
            src_req_q    <= 1'b0;
            cons_ack_q   <= rd_fire;
            cons_under_q <= rd_under;
            if (rd_fire) begin
                cons_bits_q <= peek;
            end
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (!eos_q && (fill <= FILL_W'(BUF_W - WORD_W))) begin
                        src_req_q <= 1'b1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (src_valid_i) begin
                        // Word already appended by the buffer this cycle.
                        if (src_eos_i) begin
                            eos_q   <= 1'b1;
                            state_q <= S_EOS;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (src_eos_i || (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
                        eos_q   <= 1'b1;
                        state_q <= S_EOS;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_EOS: begin
                    state_q <= S_EOS;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign src_req_o        = src_req_q;
    assign cons_ack_o       = cons_ack_q;
    assign cons_bits_o      = cons_bits_q;
    assign cons_underflow_o = cons_under_q;
    assign eos_o            = eos_q;
    assign fill_level_o     = fill;

`ifdef BFC_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_bits_q;
    logic [32:0] bits_sum;

    assign bits_sum = {1'b0, stat_bits_q} + {{(33 - NBITS_W){1'b0}}, n_eff};

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_q <= '0;
            stat_bits_q  <= '0;
        end else begin
            if (append_en && (stat_words_q != '1)) begin
                stat_words_q <= stat_words_q + 1'b1;
            end
            if (rd_fire) begin
                stat_bits_q <= bits_sum[32] ? '1 : bits_sum[31:0];
            end
        end
    end

    assign stat_words_o = stat_words_q;
    assign stat_bits_o  = stat_bits_q;
`endif

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Directed bench for bitstream_fetch_ctrl. Inputs are driven and outputs
// sampled on the falling clock edge; the design acts on the rising edge.
module tb_bitstream_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_req;
    logic [8:0] src_data;
    logic       src_valid;
    logic       src_eos;
    logic       cons_req;
    logic [3:0] cons_nbits;
    logic       cons_ack;
    logic [8:0] cons_bits;
    logic       cons_underflow;
    logic       eos;
    logic [5:0] fill_level;
`ifdef BFC_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_bits;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bitstream_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .src_req_o        (src_req),
        .src_data_i       (src_data),
        .src_valid_i      (src_valid),
        .src_eos_i        (src_eos),
        .cons_req_i       (cons_req),
        .cons_nbits_i     (cons_nbits),
        .cons_ack_o       (cons_ack),
        .cons_bits_o      (cons_bits),
        .cons_underflow_o (cons_underflow),
        .eos_o            (eos),
        .fill_level_o     (fill_level)
`ifdef BFC_STATS_EN
       ,.stat_words_o     (stat_words),
        .stat_bits_o      (stat_bits)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!src_req && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_req"}, {31'd0, src_req}, 32'd1);
    endtask

    // Answer the next fetch request two cycles after it appears.
    task automatic serve(input logic [8:0] word, input string tag);
        wait_req(tag);
        @(negedge clk);
        src_valid = 1'b1;
        src_data  = word;
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] n, input logic [8:0] exp_bits,
                          input logic exp_under, input int exp_fill, input string tag);
        int lat = 0;
        cons_nbits = n;
        cons_req   = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!cons_ack && lat < 100);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_bits"}, {23'd0, cons_bits}, {23'd0, exp_bits});
        chk({tag, "_under"}, {31'd0, cons_underflow}, {31'd0, exp_under});
        cons_req = 1'b0;
        @(negedge clk);
        chk({tag, "_fill"}, {26'd0, fill_level}, exp_fill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int reqs;
        int acks;
        rst        = 1'b1;
        src_data   = '0;
        src_valid  = 1'b0;
        src_eos    = 1'b0;
        cons_req   = 1'b0;
        cons_nbits = '0;

        // Reset then idle source
        repeat (2) @(negedge clk);
        chk("rst_src_req", {31'd0, src_req}, 32'd0);
        chk("rst_ack", {31'd0, cons_ack}, 32'd0);
        chk("rst_bits", {23'd0, cons_bits}, 32'd0);
        chk("rst_under", {31'd0, cons_underflow}, 32'd0);
        chk("rst_eos", {31'd0, eos}, 32'd0);
        chk("rst_fill", {26'd0, fill_level}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_first_req", {31'd0, src_req}, 32'd1);
        cnt  = 0;
        reqs = 0;
        while (!eos && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (src_req) reqs++;
        end
        chk("idle_eos_cycles", cnt, 32'd64);
        chk("idle_eos_flag", {31'd0, eos}, 32'd1);
        repeat (20) begin
            @(negedge clk);
            if (src_req) reqs++;
        end
        chk("idle_no_more_req", reqs, 32'd0);

        // Fill and read (first read asks for 15 bits, read as 9)
        do_reset();
        serve(9'h1A5, "fill_w0");
        serve(9'h0FF, "fill_w1");
        serve(9'h155, "fill_w2");
        repeat (2) @(negedge clk);
        chk("fill_27", {26'd0, fill_level}, 32'd27);
        rd_chk(4'd15, 9'h1A5, 1'b0, 18, "fill_rd0");
        rd_chk(4'd9,  9'h0FF, 1'b0, 9,  "fill_rd1");
        rd_chk(4'd9,  9'h155, 1'b0, 0,  "fill_rd2");

        // Mixed widths, plus a zero-length read
        do_reset();
        serve(9'b101100111, "mix_w0");
        @(negedge clk);
        rd_chk(4'd0, 9'h000,     1'b0, 9, "mix_rd0len");
        rd_chk(4'd1, 9'h001,     1'b0, 8, "mix_rd1");
        rd_chk(4'd3, 9'b011,     1'b0, 5, "mix_rd3");
        rd_chk(4'd5, 9'b00111,   1'b0, 0, "mix_rd5");

        // Simultaneous consume and append at fill 23
        do_reset();
        serve(9'h1A5, "sim_w0");
        serve(9'h0FF, "sim_w1");
        serve(9'h155, "sim_w2");
        repeat (2) @(negedge clk);
        rd_chk(4'd4, 9'hD, 1'b0, 23, "sim_rd4");
        chk("sim_req_in_flight", {31'd0, src_req}, 32'd1);
        cons_nbits = 4'd7;
        cons_req   = 1'b1;
        src_valid  = 1'b1;
        src_data   = 9'h0C3;
        @(negedge clk);
        src_valid = 1'b0;
        chk("sim_ack", {31'd0, cons_ack}, 32'd1);
        chk("sim_bits", {23'd0, cons_bits}, 32'h15);
        chk("sim_fill_25", {26'd0, fill_level}, 32'd25);
        cons_req = 1'b0;
        @(negedge clk);
        rd_chk(4'd9, 9'h1FE, 1'b0, 16, "sim_rd_a");
        rd_chk(4'd9, 9'h155, 1'b0, 7,  "sim_rd_cross");
        rd_chk(4'd7, 9'h043, 1'b0, 0,  "sim_rd_b");
        // Empty buffer, no end of stream: the read must wait.
        cons_nbits = 4'd3;
        cons_req   = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (cons_ack) acks++;
        end
        chk("wait_no_ack", acks, 32'd0);
        src_valid = 1'b1;
        src_data  = 9'h1C0;
        @(negedge clk);
        src_valid = 1'b0;
        chk("wait_no_ack_on_arrival", {31'd0, cons_ack}, 32'd0);
        @(negedge clk);
        chk("wait_ack", {31'd0, cons_ack}, 32'd1);
        chk("wait_bits", {23'd0, cons_bits}, 32'd7);
        cons_req = 1'b0;
        @(negedge clk);
        chk("wait_fill", {26'd0, fill_level}, 32'd6);

        // Underflow after end of stream
        do_reset();
        serve(9'h1B3, "und_w0");
        wait_req("und_second");
        src_eos = 1'b1;
        @(negedge clk);
        src_eos = 1'b0;
        chk("und_eos", {31'd0, eos}, 32'd1);
        rd_chk(4'd5, 9'h1B, 1'b0, 4, "und_rd5");
        rd_chk(4'd6, 9'h0C, 1'b1, 0, "und_rd6");

        // Reset while a fetch is outstanding
        do_reset();
        wait_req("mid_wait");
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        src_valid = 1'b1;
        src_data  = 9'h1FF;
        @(negedge clk);
        src_valid = 1'b0;
        chk("mid_fill_0", {26'd0, fill_level}, 32'd0);
        chk("mid_fresh_req", {31'd0, src_req}, 32'd1);
        repeat (3) @(negedge clk);
        chk("mid_fill_still_0", {26'd0, fill_level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
